// File: rtl/prnd_dither_sequencer_if.sv
// Handshake and datapath-drive bundle between the dither sequencer and its host; PRND_DITHER_SEQ_FRAME_CNT_EN adds frameCount.
// Latency: none (wires only).
// Backpressure: cfgValid/cfgReady handshake; all other signals are levels or single-cycle strobes.
interface prnd_dither_sequencer_if #(
    parameter int NUM_PRND_BITS = 5
);

    logic                     enable;
    logic                     cfgValid;
    logic                     cfgReady;
    logic [NUM_PRND_BITS:0]   cfgDivisor;
    logic [NUM_PRND_BITS-1:0] cfgWidth;
    logic                     cfgError;
    logic                     loadPulse;
    logic [NUM_PRND_BITS-1:0] prndNumber;
    logic [NUM_PRND_BITS:0]   divisor;
    logic [NUM_PRND_BITS-1:0] width;
    logic                     ditherEnable;
    logic                     busy;
`ifdef PRND_DITHER_SEQ_FRAME_CNT_EN
    logic [15:0]              frameCount;
`endif

    // Host side: requests runs and offers configurations.
    modport master (
        output enable,
        output cfgValid,
        output cfgDivisor,
        output cfgWidth,
        input  cfgReady,
        input  cfgError,
        input  loadPulse,
        input  prndNumber,
        input  divisor,
        input  width,
        input  ditherEnable,
        input  busy
`ifdef PRND_DITHER_SEQ_FRAME_CNT_EN
        , input frameCount
`endif
    );

    // Sequencer side.
    modport slave (
        input  enable,
        input  cfgValid,
        input  cfgDivisor,
        input  cfgWidth,
        output cfgReady,
        output cfgError,
        output loadPulse,
        output prndNumber,
        output divisor,
        output width,
        output ditherEnable,
        output busy
`ifdef PRND_DITHER_SEQ_FRAME_CNT_EN
        , output frameCount
`endif
    );

endinterface

// File: rtl/prnd_dither_sequencer.sv
// Dither sequencer: frame strobe, rejection-sampled frame phase, shadowed divisor/width; PRND_DITHER_SEQ_FRAME_CNT_EN adds frameCount.
// Latency: enable sampled -> START next edge -> first loadPulse the edge after; outputs move only on loadPulse edges.
// Backpressure: cfgReady drops while a staged config waits for its frame boundary; always ready in IDLE.
module prnd_dither_sequencer #(
    parameter int NUM_PRND_BITS = 5
) (
    input  logic                   clock,
    input  logic                   resetN,
    prnd_dither_sequencer_if.slave bus
);

    localparam int N = NUM_PRND_BITS;

    localparam logic [N:0]   DIV_MIN  = (N+1)'(2);
    localparam logic [N:0]   DIV_MAX  = {1'b1, {N{1'b0}}};
    localparam logic [N:0]   ONE      = (N+1)'(1);
    localparam logic [7:0]   TAPS_ALL = (N == 3) ? 8'b0000_0110 :
                                        (N == 4) ? 8'b0000_1100 :
                                        (N == 5) ? 8'b0001_0100 :
                                        (N == 6) ? 8'b0011_0000 :
                                        (N == 7) ? 8'b0110_0000 :
                                                   8'b1011_1000;
    localparam logic [N-1:0] TAPS     = TAPS_ALL[N-1:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t         state_q,       state_d;
    logic [N:0]     shadow_div_q,  shadow_div_d;
    logic [N-1:0]   shadow_wid_q,  shadow_wid_d;
    logic           shadow_full_q, shadow_full_d;
    logic [N:0]     div_q,         div_d;
    logic [N-1:0]   wid_q,         wid_d;
    logic [N-1:0]   prnd_q,        prnd_d;
    logic           load_q,        load_d;
    logic           den_q,         den_d;
    logic           err_q,         err_d;
    logic [N:0]     timer_q,       timer_d;
    logic [N-1:0]   lfsr_q,        lfsr_d;
    logic [N-1:0]   cand_q,        cand_d;
    logic           cand_vld_q,    cand_vld_d;
    logic           drain_done_q,  drain_done_d;
`ifdef PRND_DITHER_SEQ_FRAME_CNT_EN
    logic [15:0]    fc_q,          fc_d;
`endif

    logic           cfg_rdy;
    logic           cfg_fire;
    logic           cfg_bad;
    logic           frame_end;
    logic [N:0]     next_div;
    logic [N-1:0]   next_wid;

    function automatic logic [N-1:0] clamp_width(input logic [N-1:0] w, input logic [N:0] d);
        // When w exceeds d, d is below 2^N and fits in N bits.
        if ({1'b0, w} > d) begin
            clamp_width = d[N-1:0];
        end else begin
            clamp_width = w;
        end
    endfunction

    assign cfg_rdy   = !shadow_full_q || (state_q == ST_IDLE);
    assign cfg_fire  = bus.cfgValid && cfg_rdy;
    assign cfg_bad   = (bus.cfgDivisor < DIV_MIN) || (bus.cfgDivisor > DIV_MAX);
    assign frame_end = (timer_q == '0);
    assign next_div  = shadow_full_q ? shadow_div_q : div_q;
    assign next_wid  = shadow_full_q ? clamp_width(shadow_wid_q, shadow_div_q) : wid_q;

    always_comb begin
        state_d       = state_q;
        shadow_div_d  = shadow_div_q;
        shadow_wid_d  = shadow_wid_q;
        shadow_full_d = shadow_full_q;
        div_d         = div_q;
        wid_d         = wid_q;
        prnd_d        = prnd_q;
        load_d        = 1'b0;
        den_d         = den_q;
        err_d         = 1'b0;
        timer_d       = timer_q;
        cand_d        = cand_q;
        cand_vld_d    = cand_vld_q;
        drain_done_d  = drain_done_q;
`ifdef PRND_DITHER_SEQ_FRAME_CNT_EN
        fc_d          = fc_q;
`endif

        lfsr_d = (lfsr_q == '0) ? '1 : {lfsr_q[N-2:0], ^(lfsr_q & TAPS)};

        // Rejection sampler: keep the first LFSR value of the frame that fits the active divisor.
        if (!cand_vld_q && ({1'b0, lfsr_q} < div_q)) begin
            cand_d     = lfsr_q;
            cand_vld_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                den_d = 1'b0;
                if (bus.enable && shadow_full_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                div_d         = shadow_div_q;
                wid_d         = clamp_width(shadow_wid_q, shadow_div_q);
                shadow_full_d = 1'b0;
                prnd_d        = '0;
                load_d        = 1'b1;
                den_d         = 1'b1;
                timer_d       = shadow_div_q - ONE;
                cand_d        = '0;
                cand_vld_d    = 1'b0;
                state_d       = ST_RUN;
            end
            ST_RUN: begin
                if (frame_end) begin
                    div_d         = next_div;
                    wid_d         = next_wid;
                    shadow_full_d = 1'b0;
                    load_d        = 1'b1;
                    timer_d       = next_div - ONE;
                    // A shrinking divisor can strand a candidate drawn against the old one.
                    prnd_d        = ({1'b0, cand_q} < next_div) ? cand_q : '0;
                    cand_d        = '0;
                    cand_vld_d    = 1'b0;
                    if (!bus.enable) begin
                        state_d = ST_DRAIN;
                        den_d   = 1'b0;
                        prnd_d  = '0;
                    end
                end else begin
                    timer_d = timer_q - ONE;
                end
            end
            ST_DRAIN: begin
                if (drain_done_q) begin
                    drain_done_d = 1'b0;
                    state_d      = ST_IDLE;
                end else if (frame_end) begin
                    load_d       = 1'b1;
                    drain_done_d = 1'b1;
                    timer_d      = div_q - ONE;
                    cand_d       = '0;
                    cand_vld_d   = 1'b0;
                end else begin
                    timer_d = timer_q - ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Staging a new config; never collides with the boundary clear since cfgReady is low then.
        if (cfg_fire) begin
            if (cfg_bad) begin
                err_d = 1'b1;
            end else begin
                shadow_div_d  = bus.cfgDivisor;
                shadow_wid_d  = clamp_width(bus.cfgWidth, bus.cfgDivisor);
                shadow_full_d = 1'b1;
            end
        end

`ifdef PRND_DITHER_SEQ_FRAME_CNT_EN
        if (state_d == ST_START) begin
            fc_d = '0;
        end else if (load_d && (state_d == ST_RUN) && (fc_q != 16'hFFFF)) begin
            fc_d = fc_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            shadow_div_q  <= DIV_MIN;
            shadow_wid_q  <= '0;
            shadow_full_q <= 1'b0;
            div_q         <= DIV_MIN;
            wid_q         <= '0;
            prnd_q        <= '0;
            load_q        <= 1'b0;
            den_q         <= 1'b0;
            err_q         <= 1'b0;
            timer_q       <= '0;
            lfsr_q        <= '1;
            cand_q        <= '0;
            cand_vld_q    <= 1'b0;
            drain_done_q  <= 1'b0;
`ifdef PRND_DITHER_SEQ_FRAME_CNT_EN
            fc_q          <= '0;
`endif
        end else begin
            state_q       <= state_d;
            shadow_div_q  <= shadow_div_d;
            shadow_wid_q  <= shadow_wid_d;
            shadow_full_q <= shadow_full_d;
            div_q         <= div_d;
            wid_q         <= wid_d;
            prnd_q        <= prnd_d;
            load_q        <= load_d;
            den_q         <= den_d;
            err_q         <= err_d;
            timer_q       <= timer_d;
            lfsr_q        <= lfsr_d;
            cand_q        <= cand_d;
            cand_vld_q    <= cand_vld_d;
            drain_done_q  <= drain_done_d;
`ifdef PRND_DITHER_SEQ_FRAME_CNT_EN
            fc_q          <= fc_d;
`endif
        end
    end

    assign bus.cfgReady     = cfg_rdy;
    assign bus.cfgError     = err_q;
    assign bus.loadPulse    = load_q;
    assign bus.prndNumber   = prnd_q;
    assign bus.divisor      = div_q;
    assign bus.width        = wid_q;
    assign bus.ditherEnable = den_q;
    assign bus.busy         = (state_q != ST_IDLE);
`ifdef PRND_DITHER_SEQ_FRAME_CNT_EN
    assign bus.frameCount   = fc_q;
`endif

endmodule

// File: tb/tb_prnd_dither_sequencer.sv
// Scoreboard bench for prnd_dither_sequencer: stimulus queues expected frame strobes, a negedge monitor checks them.
// Latency: n/a.
// Backpressure: exercises the cfgReady stall while a staged config waits for its boundary.
module tb_prnd_dither_sequencer;

    localparam int N = 5;

    logic clock = 1'b0;
    logic resetN;

    always #5 clock = ~clock;

    prnd_dither_sequencer_if #(.NUM_PRND_BITS(N)) bus ();

    prnd_dither_sequencer #(.NUM_PRND_BITS(N)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    typedef struct {
        int at;
        int dv;
        int wd;
        int den;
        int prnd;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [19:0] seen20   = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push_exp(input int at, input int dv, input int wd, input int den, input int prnd);
        exp_t e;
        e.at = at; e.dv = dv; e.wd = wd; e.den = den; e.prnd = prnd;
        sb.push_back(e);
    endtask

    // Every frame strobe is matched against the oldest queued expectation.
    always @(negedge clock) begin
        if (bus.loadPulse === 1'b1) begin
            check("prnd_below_divisor", (bus.prndNumber < bus.divisor) ? 1 : 0, 1);
            check("width_within_divisor", ({1'b0, bus.width} <= bus.divisor) ? 1 : 0, 1);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: loadPulse at cycle %0d, none expected", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_cycle", cyc, mon_e.at);
                check("pulse_divisor", bus.divisor, mon_e.dv);
                check("pulse_width", bus.width, mon_e.wd);
                check("pulse_dither_enable", bus.ditherEnable, mon_e.den);
                if (mon_e.prnd >= 0) check("pulse_prnd", bus.prndNumber, mon_e.prnd);
            end
            if (bus.divisor == 20 && bus.prndNumber < 20) seen20[bus.prndNumber] = 1'b1;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfgReady"}, bus.cfgReady, 1);
        check({tag, "_cfgError"}, bus.cfgError, 0);
        check({tag, "_loadPulse"}, bus.loadPulse, 0);
        check({tag, "_prndNumber"}, bus.prndNumber, 0);
        check({tag, "_divisor"}, bus.divisor, 2);
        check({tag, "_width"}, bus.width, 0);
        check({tag, "_ditherEnable"}, bus.ditherEnable, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    task automatic wait_pulse(input string name);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.loadPulse !== 1'b1 && n < 300);
        if (bus.loadPulse !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no loadPulse within %0d cycles", name, n);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cfg(input int dv, input int wd, output int stall, output logic err);
        bus.cfgValid   = 1'b1;
        bus.cfgDivisor = (N+1)'(dv);
        bus.cfgWidth   = N'(wd);
        stall = 0;
        while (bus.cfgReady !== 1'b1 && stall < 300) begin
            @(negedge clock);
            stall++;
        end
        @(negedge clock);
        bus.cfgValid = 1'b0;
        err = bus.cfgError;
    endtask

    initial begin
        int   stall;
        logic err;
        int   c;
        int   d;

        resetN         = 1'b0;
        bus.enable     = 1'b0;
        bus.cfgValid   = 1'b0;
        bus.cfgDivisor = '0;
        bus.cfgWidth   = '0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        resetN = 1'b1;
        @(negedge clock);

        // Good config, then two out-of-range divisors that must not disturb the shadow.
        send_cfg(32, 10, stall, err);
        check("cfg32_stall", stall, 0);
        check("cfg32_err", err, 0);
        send_cfg(1, 7, stall, err);
        check("cfg_div1_err", err, 1);
        send_cfg(33, 7, stall, err);
        check("cfg_div33_err", err, 1);
        @(negedge clock);
        check("cfg_err_cleared", bus.cfgError, 0);
        check("idle_ready_with_shadow", bus.cfgReady, 1);
        check("idle_busy", bus.busy, 0);

        c = cyc;
        bus.enable = 1'b1;
        push_exp(c + 2,  32, 10, 1, 0);
        push_exp(c + 34, 24, 24, 1, -1);
        push_exp(c + 58, 16, 3,  1, -1);
        push_exp(c + 74, 16, 3,  0, 0);
        push_exp(c + 90, 16, 3,  0, 0);

        wait_pulse("first_pulse");
        check("run_busy", bus.busy, 1);
        repeat (3) @(negedge clock);
        send_cfg(24, 30, stall, err);
        check("cfg24_stall", stall, 0);
        check("cfg24_err", err, 0);
        check("ready_low_staged", bus.cfgReady, 0);
        send_cfg(16, 3, stall, err);
        check("cfg16_stall_to_boundary", stall, 28);
        check("cfg16_err", err, 0);

        wait_pulse("cfg16_applied");
        repeat (5) @(negedge clock);
        bus.enable = 1'b0;
        wait_pulse("drain_start");
        wait_pulse("drain_end");
        check("busy_on_final_pulse", bus.busy, 1);
        @(negedge clock);
        check("busy_after_drain", bus.busy, 0);
        check("pulse_low_after_drain", bus.loadPulse, 0);

        // Long run at divisor 20: phase coverage and strict 20-cycle spacing.
        send_cfg(20, 5, stall, err);
        check("cfg20_err", err, 0);
        d = cyc;
        bus.enable = 1'b1;
        for (int k = 0; k < 500; k++) push_exp(d + 2 + 20 * k, 20, 5, 1, (k == 0) ? 0 : -1);
        for (int k = 0; k < 500; k++) wait_pulse("run20");

        // Asynchronous reset inside a strobe cycle.
        #1 resetN = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        check("scoreboard_drained", sb.size(), 0);
        check("phase_coverage_0_19", seen20, 20'hF_FFFF);
        @(negedge clock);
        resetN = 1'b1;
        repeat (40) @(negedge clock);
        check("post_reset_idle_busy", bus.busy, 0);
        check("post_reset_idle_den", bus.ditherEnable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prnd_dither_sequencer.md
# prnd_dither_sequencer

Sequencer for the pseudorandom PWM dither datapath. It owns the frame timing (`clockSlow` load strobe) and generates a per-frame pseudorandom phase in the range [0, divisor). It also holds divisor and width in shadow registers that change only on frame boundaries, and it runs a clean start/stop sequence so the dither counters never load a torn configuration. It runs on the fast dither clock and drives the dither datapath's `clockSlow`, `prndNumber`, `width`, `divisor` and `enable` inputs directly.

## Interface
- `NUM_PRND_BITS`, default 5: dither resolution; legal values 3..8.
- `clock`  in  1  fast dither clock; the same clock the dither counters use.
- `resetN`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request, level-sensitive.
- `cfgValid`  in  1  configuration offer.
- `cfgReady`  out  1  configuration accepted on an edge where `cfgValid` and `cfgReady` are both high.
- `cfgDivisor`  in  NUM_PRND_BITS+1  frame length in cycles; legal range 2..2^NUM_PRND_BITS.
- `cfgWidth`  in  NUM_PRND_BITS  high time per frame.
- `cfgError`  out  1  one-cycle pulse when an offered configuration is rejected.
- `loadPulse`  out  1  frame strobe; drives the datapath's `clockSlow`.
- `prndNumber`  out  NUM_PRND_BITS  frame phase; always less than `divisor`.
- `divisor`  out  NUM_PRND_BITS+1  active divisor.
- `width`  out  NUM_PRND_BITS  active width.
- `ditherEnable`  out  1  drives the datapath's `enable`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset values: state IDLE; `cfgReady` = 1; `cfgError` = 0; `loadPulse` = 0; `prndNumber` = 0; `divisor` = 2; `width` = 0; `ditherEnable` = 0; `busy` = 0. Shadow register empty. LFSR = all ones.
- Config accept:
  - `cfgDivisor` < 2 or > 2^N: the handshake still completes, `cfgError` pulses, and the shadow register is unchanged.
  - Otherwise the shadow register stores divisor and min(`cfgWidth`, divisor), and the shadow-full flag is set.
  - `cfgReady` = !shadowFull || state == IDLE. In IDLE a new offer overwrites the shadow.
- LFSR: Fibonacci, steps every cycle in all states. Maximal-length taps are N=3: 3,2; N=4: 4,3; N=5: 5,3; N=6: 6,5; N=7: 7,6; N=8: 8,6,5,4. If the LFSR state is zero it is forced to all ones.
- Phase selection by rejection sampling within each frame:
  - The first LFSR value below the active divisor is latched into `candidate`.
  - If no value qualifies before the frame ends, `candidate` = 0.
- States:
  - IDLE: `loadPulse` = 0, `ditherEnable` = 0. When `enable` is high and the shadow is full → START. When `enable` is high and the shadow is empty, stay in IDLE.
  - START (1 cycle): copy shadow to the active registers, clear shadowFull, `prndNumber` = 0 → RUN.
  - RUN: `ditherEnable` = 1. Frame timer loads divisor−1 and counts down. When the timer is 0:
    - Start the next frame.
    - If the shadow is full, apply it (active regs ← shadow, clear the flag).
    - Present `candidate` on `prndNumber`.
    - Rearm the sampler.
    - If `enable` is low → DRAIN.
  - DRAIN: one frame with `ditherEnable` = 0 and `prndNumber` = 0, ending with a final `loadPulse`. Then → IDLE.
- Width clamp: width is re-checked against the divisor when the shadow is applied, so `width` ≤ `divisor` always holds at the outputs.

## Timing
- `loadPulse` is high for exactly one cycle per frame, on the first cycle of each frame. Successive pulses are `divisor` cycles apart.
- `prndNumber`, `width`, `divisor` and `ditherEnable` change only on the edge that raises `loadPulse`. They are stable for the whole pulse cycle, so the counters sample a consistent set.
- Start latency: `enable` rises (with the shadow full) at edge k → START at k+1 → first `loadPulse` at k+2.
- Stop: `enable` may fall mid-frame. The current frame completes, one full DRAIN frame follows, and the final `loadPulse` carries `ditherEnable` = 0. `busy` falls the cycle after that pulse.
- `enable` rising again during DRAIN: the DRAIN frame completes, then IDLE follows, then restart per the rules above.
- A config accepted on the same edge as a frame boundary is applied at the next boundary, not the current one.
- `resetN` low at any point forces the reset values immediately, including `loadPulse` = 0 mid-frame.

## Configuration
- `PRND_DITHER_SEQ_FRAME_CNT_EN` defined: adds output `frameCount` (16 bits). It is cleared in START, increments on each RUN `loadPulse`, saturates at 0xFFFF, and resets to 0.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset, then config divisor=32, width=10, then raise `enable` → first `loadPulse` 2 cycles later; then pulses every 32 cycles; `width` = 10; `ditherEnable` = 1.
- Config divisor=1, then divisor=33 (N=5) → `cfgError` pulses twice; the shadow keeps the prior value.
- Divisor=20 for 500 frames → every `prndNumber` < 20; every value 0..19 appears at least once.
- Mid-run config divisor=24, width=30 → applied exactly at the next frame boundary with width clamped to 24; a second offer stalls (`cfgReady` = 0) until then.
- Drop `enable` at frame cycle 5 → the frame completes, one DRAIN frame follows, the last pulse has `ditherEnable` = 0, and `busy` falls the next cycle.
- Assert `resetN` low mid-frame in RUN → all outputs are at their reset values with no clock edge required; after release the block waits in IDLE for a new config.
